// File: rtl/trace_stream_engine.sv
// -----------------------------------------------------------------------------
// trace_stream_engine
//
// FPGA-side engine of the Data Trace Buffer.
//
// Trace mode packs 1..MAX_TRACES trace bits per cycle into WIDTH-bit words.
// Capture is armed, a rising edge on FPGA_TRIG_I marks the trigger word, and
// DELAY_I further words are stored before capture stops by itself.
// Stream mode fetches memory words through a pending/stream double buffer and
// hands them to the FPGA as num_trc-bit slices with a read/valid handshake.
//
// Ports
//   FPGA_CLK_I     clock
//   RST_I          synchronous active-high reset
//   EN_I           enable (level); low returns to IDLE
//   MODE_I         0 = trace, 1 = stream; latched when leaving IDLE
//   NTRACE_I       log2 of traces per cycle (clamped to MAX_TRACES)
//   DELAY_I        words stored after the trigger word; latched at trigger
//   EVENT_POS_O    bit position of the trigger sample inside its word
//   TRG_EVENT_O    sticky: trigger seen
//   TRG_DONE_O     post-trigger delay expired, capture halted
//   DATA_O         completed trace word (registered)
//   STORE_O        one-cycle strobe qualifying DATA_O
//   DATA_I         memory read data
//   REQ_O          one-cycle memory read request
//   LOAD_I         DATA_I valid strobe
//   OVERRUN_O      sticky: LOAD_I arrived with no request outstanding
//   FPGA_TRIG_I    trigger input
//   FPGA_TRACE_I   trace bits; only the low num_trc bits are used
//   FPGA_READ_I    stream consume
//   FPGA_STREAM_O  current stream slice, zero above num_trc
//   FPGA_TRIG_O    trace mode: TRG_DONE_O; stream mode: slice valid
// -----------------------------------------------------------------------------
module trace_stream_engine #(
    parameter int WIDTH       = 32,
    parameter int MAX_TRACES  = 8,
    parameter int NTRACE_BITS = 2,
    parameter int DELAY_BITS  = 8
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic                     EN_I,
    input  logic                     MODE_I,
    input  logic [NTRACE_BITS-1:0]   NTRACE_I,
    input  logic [DELAY_BITS-1:0]    DELAY_I,
    output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
    output logic                     TRG_EVENT_O,
    output logic                     TRG_DONE_O,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     STORE_O,
    input  logic [WIDTH-1:0]         DATA_I,
    output logic                     REQ_O,
    input  logic                     LOAD_I,
    output logic                     OVERRUN_O,
    input  logic                     FPGA_TRIG_I,
    input  logic [MAX_TRACES-1:0]    FPGA_TRACE_I,
    input  logic                     FPGA_READ_I,
    output logic [MAX_TRACES-1:0]    FPGA_STREAM_O,
    output logic                     FPGA_TRIG_O
);

    localparam int POS_W  = $clog2(WIDTH);
    localparam int CNT_W  = POS_W + 1;          // wide enough to hold WIDTH itself
    localparam int MT_LOG = $clog2(MAX_TRACES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_DONE,
        S_STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [WIDTH-1:0]        trace_q, trace_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    store_q, store_d;
    logic [POS_W-1:0]        evpos_q, evpos_d;
    logic                    trg_evt_q, trg_evt_d;
    logic                    trg_done_q, trg_done_d;
    logic                    trg_prev_q, trg_prev_d;
    logic [DELAY_BITS-1:0]   cnt_q, cnt_d;
    logic                    trg_open_q, trg_open_d;
    logic                    req_q, req_d;
    logic                    req_out_q, req_out_d;
    logic                    overrun_q, overrun_d;
    logic [WIDTH-1:0]        pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic [WIDTH-1:0]        strm_q, strm_d;
    logic [POS_W-1:0]        spos_q, spos_d;
    logic                    vld_q, vld_d;

    logic [CNT_W-1:0]        num_trc;
    logic [POS_W-1:0]        last_pos;
    logic [POS_W-1:0]        pos_step;
    logic [WIDTH-1:0]        cap_word;
    logic [MAX_TRACES-1:0]   slice;
    logic                    trig_edge;
    logic                    wrap;
    logic                    swrap;
    logic                    drain;

    // Traces per cycle, clamped so NTRACE_I values beyond MAX_TRACES saturate.
    always_comb begin
        num_trc = CNT_W'(MAX_TRACES);
        if (int'(NTRACE_I) < MT_LOG) begin
            num_trc = CNT_W'(1) << NTRACE_I;
        end
    end

    // Positions are multiples of num_trc, so the last slot is WIDTH-num_trc and
    // adding num_trc there wraps exactly to zero in POS_W bits.
    assign last_pos = POS_W'(WIDTH - int'(num_trc));
    assign pos_step = POS_W'(num_trc);
    assign wrap     = (pos_q == last_pos);
    assign swrap    = (spos_q == last_pos);

    assign trig_edge = FPGA_TRIG_I & ~trg_prev_q;

    // Current word with this cycle's sample merged in; on a wrap this is the
    // completed word, so the final sample is never lost.
    always_comb begin
        cap_word = trace_q;
        for (int i = 0; i < MAX_TRACES; i++) begin
            if (CNT_W'(i) < num_trc) begin
                cap_word[pos_q + POS_W'(i)] = FPGA_TRACE_I[i];
            end
        end
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < MAX_TRACES; i++) begin
            if (CNT_W'(i) < num_trc) begin
                slice[i] = strm_q[spos_q + POS_W'(i)];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pos_d       = pos_q;
        trace_d     = trace_q;
        data_d      = data_q;
        store_d     = 1'b0;
        evpos_d     = evpos_q;
        trg_evt_d   = trg_evt_q;
        trg_done_d  = trg_done_q;
        trg_prev_d  = FPGA_TRIG_I;
        cnt_d       = cnt_q;
        trg_open_d  = trg_open_q;
        req_d       = 1'b0;
        req_out_d   = req_out_q;
        overrun_d   = overrun_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        strm_d      = strm_q;
        spos_d      = spos_q;
        vld_d       = vld_q;
        drain       = 1'b0;

        if (!EN_I) begin
            // Sticky flags survive disable; they are cleared on the next arm.
            state_d     = S_IDLE;
            pos_d       = '0;
            trace_d     = '0;
            trg_open_d  = 1'b0;
            req_out_d   = 1'b0;
            pend_d      = '0;
            pend_full_d = 1'b0;
            strm_d      = '0;
            spos_d      = '0;
            vld_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mode_d     = MODE_I;
                    state_d    = MODE_I ? S_STREAM : S_ARMED;
                    trg_evt_d  = 1'b0;
                    trg_done_d = 1'b0;
                    overrun_d  = 1'b0;
                    evpos_d    = '0;
                    pos_d      = '0;
                end

                S_ARMED, S_DELAY: begin
                    trace_d = cap_word;
                    pos_d   = wrap ? '0 : pos_q + pos_step;
                    if (wrap) begin
                        data_d  = cap_word;
                        store_d = 1'b1;
                    end

                    if (state_q == S_ARMED) begin
                        if (trig_edge) begin
                            evpos_d   = pos_q;
                            trg_evt_d = 1'b1;
                            cnt_d     = DELAY_I;
                            state_d   = S_DELAY;
                            // A trigger on the wrap cycle completes its own
                            // word right now; otherwise that word is still open.
                            trg_open_d = ~wrap;
                            if (wrap && (DELAY_I == '0)) begin
                                state_d    = S_DONE;
                                trg_done_d = 1'b1;
                            end
                        end
                    end else if (wrap) begin
                        if (trg_open_q) begin
                            // Completion of the trigger word: no count consumed.
                            trg_open_d = 1'b0;
                            if (cnt_q == '0) begin
                                state_d    = S_DONE;
                                trg_done_d = 1'b1;
                            end
                        end else begin
                            // cnt_q is the number of delay words still owed,
                            // so the word that consumes the last one is final.
                            if (cnt_q <= DELAY_BITS'(1)) begin
                                state_d    = S_DONE;
                                trg_done_d = 1'b1;
                            end
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - DELAY_BITS'(1);
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_d = S_DONE;
                end

                S_STREAM: begin
                    if (!pend_full_q && !req_out_q) begin
                        req_d     = 1'b1;
                        req_out_d = 1'b1;
                    end

                    if (!vld_q) begin
                        if (pend_full_q) begin
                            strm_d = pend_q;
                            spos_d = '0;
                            vld_d  = 1'b1;
                            drain  = 1'b1;
                        end
                    end else if (FPGA_READ_I) begin
                        if (swrap) begin
                            // Reload in the same cycle to avoid a valid bubble.
                            if (pend_full_q) begin
                                strm_d = pend_q;
                                spos_d = '0;
                                drain  = 1'b1;
                            end else begin
                                vld_d = 1'b0;
                            end
                        end else begin
                            spos_d = spos_q + pos_step;
                        end
                    end

                    if (drain) begin
                        pend_full_d = 1'b0;
                    end

                    // Accept after the drain so a load can land in a slot
                    // freed this same cycle.
                    if (LOAD_I) begin
                        if (req_out_q) begin
                            pend_d      = DATA_I;
                            pend_full_d = 1'b1;
                            req_out_d   = 1'b0;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            pos_q       <= '0;
            trace_q     <= '0;
            data_q      <= '0;
            store_q     <= 1'b0;
            evpos_q     <= '0;
            trg_evt_q   <= 1'b0;
            trg_done_q  <= 1'b0;
            trg_prev_q  <= 1'b0;
            cnt_q       <= '0;
            trg_open_q  <= 1'b0;
            req_q       <= 1'b0;
            req_out_q   <= 1'b0;
            overrun_q   <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            strm_q      <= '0;
            spos_q      <= '0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            trace_q     <= trace_d;
            data_q      <= data_d;
            store_q     <= store_d;
            evpos_q     <= evpos_d;
            trg_evt_q   <= trg_evt_d;
            trg_done_q  <= trg_done_d;
            trg_prev_q  <= trg_prev_d;
            cnt_q       <= cnt_d;
            trg_open_q  <= trg_open_d;
            req_q       <= req_d;
            req_out_q   <= req_out_d;
            overrun_q   <= overrun_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            strm_q      <= strm_d;
            spos_q      <= spos_d;
            vld_q       <= vld_d;
        end
    end

    assign EVENT_POS_O   = evpos_q;
    assign TRG_EVENT_O   = trg_evt_q;
    assign TRG_DONE_O    = trg_done_q;
    assign DATA_O        = data_q;
    assign STORE_O       = store_q;
    assign REQ_O         = req_q;
    assign OVERRUN_O     = overrun_q;
    assign FPGA_STREAM_O = slice;
    assign FPGA_TRIG_O   = mode_q ? vld_q : trg_done_q;

endmodule

// File: tb/tb_trace_stream_engine.sv
// -----------------------------------------------------------------------------
// Testbench for trace_stream_engine: trace packing, trigger/delay, stream
// slicing with a simple memory responder, enable drop and reset.
// -----------------------------------------------------------------------------
module tb_trace_stream_engine;

    localparam int WIDTH       = 32;
    localparam int MAX_TRACES  = 8;
    localparam int NTRACE_BITS = 2;
    localparam int DELAY_BITS  = 8;
    localparam int POS_W       = $clog2(WIDTH);

    logic                   FPGA_CLK_I = 1'b0;
    logic                   RST_I = 1'b1;
    logic                   EN_I = 1'b0;
    logic                   MODE_I = 1'b0;
    logic [NTRACE_BITS-1:0] NTRACE_I = '0;
    logic [DELAY_BITS-1:0]  DELAY_I = '0;
    logic [POS_W-1:0]       EVENT_POS_O;
    logic                   TRG_EVENT_O;
    logic                   TRG_DONE_O;
    logic [WIDTH-1:0]       DATA_O;
    logic                   STORE_O;
    logic [WIDTH-1:0]       DATA_I = '0;
    logic                   REQ_O;
    logic                   LOAD_I = 1'b0;
    logic                   OVERRUN_O;
    logic                   FPGA_TRIG_I = 1'b0;
    logic [MAX_TRACES-1:0]  FPGA_TRACE_I = '0;
    logic                   FPGA_READ_I = 1'b0;
    logic [MAX_TRACES-1:0]  FPGA_STREAM_O;
    logic                   FPGA_TRIG_O;

    always #5 FPGA_CLK_I = ~FPGA_CLK_I;

    trace_stream_engine #(
        .WIDTH(WIDTH), .MAX_TRACES(MAX_TRACES),
        .NTRACE_BITS(NTRACE_BITS), .DELAY_BITS(DELAY_BITS)
    ) dut (
        .FPGA_CLK_I(FPGA_CLK_I), .RST_I(RST_I), .EN_I(EN_I), .MODE_I(MODE_I),
        .NTRACE_I(NTRACE_I), .DELAY_I(DELAY_I), .EVENT_POS_O(EVENT_POS_O),
        .TRG_EVENT_O(TRG_EVENT_O), .TRG_DONE_O(TRG_DONE_O), .DATA_O(DATA_O),
        .STORE_O(STORE_O), .DATA_I(DATA_I), .REQ_O(REQ_O), .LOAD_I(LOAD_I),
        .OVERRUN_O(OVERRUN_O), .FPGA_TRIG_I(FPGA_TRIG_I),
        .FPGA_TRACE_I(FPGA_TRACE_I), .FPGA_READ_I(FPGA_READ_I),
        .FPGA_STREAM_O(FPGA_STREAM_O), .FPGA_TRIG_O(FPGA_TRIG_O)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Scoreboards: stored words and stream slices, in expected order.
    logic [WIDTH-1:0]      wq[$];
    logic [MAX_TRACES-1:0] sq[$];

    // Memory responder: words to return, one per REQ_O, three cycles later.
    logic [WIDTH-1:0] mem_words[$];
    int               mem_due   = -1;
    int               strm_ntr  = 4;
    logic             spur_load = 1'b0;
    logic [WIDTH-1:0] spur_data = '0;

    int store_cnt, first_store_cyc, last_store_cyc, done_cyc;
    int req_cnt, rd_cnt, first_rd_cyc, last_rd_cyc;
    int en_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        store_cnt       = 0;
        first_store_cyc = -1;
        last_store_cyc  = -1;
        done_cyc        = -1;
        req_cnt         = 0;
        rd_cnt          = 0;
        first_rd_cyc    = -1;
        last_rd_cyc     = -1;
    endtask

    // One clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] w;
        @(posedge FPGA_CLK_I);
        #1;
        cyc++;
        if (REQ_O && mem_due < 0 && mem_words.size() > 0) mem_due = cyc + 3;
        if (cyc == mem_due) begin
            w      = mem_words.pop_front();
            DATA_I = w;
            LOAD_I = 1'b1;
            for (int k = 0; k < WIDTH / strm_ntr; k++)
                sq.push_back(MAX_TRACES'((w >> (k * strm_ntr)) & ((32'd1 << strm_ntr) - 1)));
            mem_due = -1;
        end else if (spur_load) begin
            DATA_I = spur_data;
            LOAD_I = 1'b1;
        end else begin
            LOAD_I = 1'b0;
        end
    endtask

    // Output monitor on the falling edge.
    always @(negedge FPGA_CLK_I) begin
        if (STORE_O) begin
            store_cnt++;
            last_store_cyc = cyc;
            if (first_store_cyc < 0) first_store_cyc = cyc;
            if (wq.size() > 0) chk("store_data", DATA_O, wq.pop_front());
            else               chk("unexpected_store", STORE_O, 0);
        end
        if (TRG_DONE_O && done_cyc < 0) done_cyc = cyc;
        if (REQ_O) req_cnt++;
        if (FPGA_TRIG_O && FPGA_READ_I) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            if (sq.size() > 0) chk("slice", FPGA_STREAM_O, sq.pop_front());
            else               chk("unexpected_slice", FPGA_TRIG_O, 0);
        end
    end

    task automatic arm(input logic mode, input logic [NTRACE_BITS-1:0] ntr_sel);
        MODE_I   = mode;
        NTRACE_I = ntr_sel;
        EN_I     = 1'b1;
        en_cyc   = cyc;
        tick();
        clear_stats();
    endtask

    task automatic disarm();
        EN_I        = 1'b0;
        FPGA_TRIG_I = 1'b0;
        FPGA_READ_I = 1'b0;
        tick();
        tick();
    endtask

    // Drive nsamp trace samples; expected words 0..nstore-1 go to the
    // scoreboard. pat 0: bit0 alternates 1,0 with noise above; pat 1: counter.
    task automatic feed(input int ntr, input int nsamp, input int trig_n,
                        input int nstore, input int pat);
        logic [WIDTH-1:0] acc;
        logic [7:0]       v;
        int               spw;
        spw = WIDTH / ntr;
        acc = '0;
        for (int n = 0; n < nsamp; n++) begin
            if (pat == 0) begin
                v    = 8'($urandom);
                v[0] = (n % 2 == 0);
            end else begin
                v = 8'(n * 37 + 5);
            end
            for (int b = 0; b < ntr; b++) acc[(n % spw) * ntr + b] = v[b];
            if (n % spw == spw - 1) begin
                if (n / spw < nstore) wq.push_back(acc);
                acc = '0;
            end
            FPGA_TRACE_I = v;
            FPGA_TRIG_I  = (trig_n >= 0) && (n >= trig_n);
            tick();
        end
        tick();
    endtask

    initial begin
        clear_stats();
        // Reset
        tick();
        tick();
        chk("rst_store", STORE_O, 0);
        chk("rst_data", DATA_O, 0);
        chk("rst_flags", {TRG_EVENT_O, TRG_DONE_O, OVERRUN_O, REQ_O, FPGA_TRIG_O}, 0);
        chk("rst_evpos", EVENT_POS_O, 0);
        RST_I = 1'b0;
        tick();

        // 1 trace, alternating bit -> 0x55555555 every 32 cycles
        arm(1'b0, 2'd0);
        feed(1, 96, -1, 3, 0);
        chk("t1_first_store_latency", first_store_cyc - en_cyc, 33);
        chk("t1_store_count", store_cnt, 3);
        chk("t1_queue_empty", wq.size(), 0);
        disarm();

        // 8 traces, trigger at 3rd sample of word 1, DELAY_I=2
        DELAY_I = 8'd2;
        arm(1'b0, 2'd3);
        feed(8, 28, 6, 4, 1);
        chk("t2_event_pos", EVENT_POS_O, 16);
        chk("t2_trg_event", TRG_EVENT_O, 1);
        chk("t2_trg_done", TRG_DONE_O, 1);
        chk("t2_fpga_trig", FPGA_TRIG_O, 1);
        chk("t2_store_count", store_cnt, 4);
        chk("t2_done_with_final_store", done_cyc, last_store_cyc);
        chk("t2_queue_empty", wq.size(), 0);
        disarm();

        // DELAY_I=0, trigger on the wrap cycle
        DELAY_I = 8'd0;
        arm(1'b0, 2'd3);
        feed(8, 16, 3, 1, 1);
        chk("t3_event_pos", EVENT_POS_O, 24);
        chk("t3_store_count", store_cnt, 1);
        chk("t3_done_with_store", done_cyc, last_store_cyc);
        chk("t3_queue_empty", wq.size(), 0);
        disarm();
        chk("t3_flags_held_disabled", {TRG_EVENT_O, TRG_DONE_O}, 2'b11);

        // Enable drop mid-word, then re-arm
        arm(1'b0, 2'd3);
        chk("t6_flags_cleared", {TRG_EVENT_O, TRG_DONE_O}, 0);
        chk("t6_evpos_cleared", EVENT_POS_O, 0);
        feed(8, 2, -1, 0, 1);
        disarm();
        chk("t6_no_partial_store", store_cnt, 0);
        arm(1'b0, 2'd3);
        feed(8, 4, -1, 1, 1);
        chk("t6_restart_store_count", store_cnt, 1);
        chk("t6_queue_empty", wq.size(), 0);

        // Reset while in DELAY
        disarm();
        DELAY_I = 8'd5;
        arm(1'b0, 2'd3);
        feed(8, 2, 1, 0, 1);
        chk("t7_in_delay", TRG_EVENT_O, 1);
        RST_I = 1'b1;
        tick();
        chk("t7_rst_flags", {TRG_EVENT_O, TRG_DONE_O, STORE_O, FPGA_TRIG_O}, 0);
        chk("t7_rst_data", DATA_O, 0);
        chk("t7_rst_evpos", EVENT_POS_O, 0);
        RST_I = 1'b0;
        disarm();

        // Stream, 4 traces, read held high, two words back to back
        strm_ntr = 4;
        mem_words.push_back(32'h7654_3210);
        mem_words.push_back(32'hFEDC_BA98);
        FPGA_READ_I = 1'b1;
        arm(1'b1, 2'd2);
        repeat (45) tick();
        chk("t4_slices_read", rd_cnt, 16);
        chk("t4_no_valid_gap", last_rd_cyc - first_rd_cyc, 15);
        chk("t4_slice_queue_empty", sq.size(), 0);
        chk("t4_valid_dropped", FPGA_TRIG_O, 0);
        chk("t4_no_overrun", OVERRUN_O, 0);
        disarm();
        mem_words.delete();
        sq.delete();
        mem_due = -1;

        // Stream, read held low: two requests only, then spurious load
        mem_words.push_back(32'h0F1E_2D3C);
        mem_words.push_back(32'h4B5A_6978);
        arm(1'b1, 2'd2);
        repeat (30) tick();
        chk("t5_req_count", req_cnt, 2);
        chk("t5_valid", FPGA_TRIG_O, 1);
        chk("t5_first_slice", FPGA_STREAM_O, 8'h0C);
        spur_data = 32'hDEAD_BEEF;
        spur_load = 1'b1;
        tick();
        spur_load = 1'b0;
        tick();
        chk("t5_overrun", OVERRUN_O, 1);
        FPGA_READ_I = 1'b1;
        repeat (25) tick();
        chk("t5_slices_read", rd_cnt, 16);
        chk("t5_slice_queue_empty", sq.size(), 0);
        chk("t5_overrun_sticky", OVERRUN_O, 1);
        disarm();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
